// File: rtl/pll_phase_pkg.sv
// Shared types and helpers for the multi-channel phase divider.
// Holds the per-channel state encoding and divide-ratio clamping.
// No logic of its own; imported by the channel and top modules.
package pll_phase_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2
  } chan_state_t;

  // A divide ratio of zero behaves exactly like a ratio of one.
  function automatic int unsigned clamp_div(input int unsigned n);
    return (n == 0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/pll_phase_chan.sv
// One divider channel: optional start delay, then a wrapping period counter with pulse/square decode.
// Latency: sync sampled at edge k -> first clken k+1+phase cycles later; outputs decode registers only.
// No backpressure; in_delay reports the delay phase so the top can hold off config writes.
module pll_phase_chan
  import pll_phase_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int PH_W  = 8
)(
  input  logic             referenceclk,
  input  logic             resetb,
  input  logic             sync,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [PH_W-1:0]  cfg_phase,
  input  logic             cfg_en,
  output logic             clken,
  output logic             phaseout,
  output logic             in_delay
);

  chan_state_t      state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] n, n_nxt;
  logic [PH_W-1:0]  dcnt, dcnt_nxt;
  logic [DIV_W:0]   half;

  // State, counters and the ratio captured at the last sync.
  always_ff @(posedge referenceclk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      cnt   <= '0;
      n     <= DIV_W'(1);
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      n     <= n_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next state: sync always restarts from the shadow config, otherwise delay down then count the period.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_nxt     = n;
    dcnt_nxt  = dcnt;
    if (sync) begin
      n_nxt    = DIV_W'(clamp_div(32'(cfg_div)));
      cnt_nxt  = '0;
      dcnt_nxt = cfg_phase;
      if (!cfg_en)
        state_nxt = IDLE;
      else if (cfg_phase != '0)
        state_nxt = DELAY;
      else
        state_nxt = RUN;
    end else begin
      case (state)
        DELAY: begin
          if (dcnt <= PH_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            dcnt_nxt = dcnt - PH_W'(1);
          end
        end
        RUN:     cnt_nxt = (cnt == n - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
        IDLE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // High for the first ceil(N/2) counts; one extra bit so N=2^DIV_W-1 does not overflow.
  assign half     = ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
  assign clken    = (state == RUN) && (cnt == '0);
  assign phaseout = (state == RUN) && ({1'b0, cnt} < half);
  assign in_delay = (state == DELAY);

endmodule

// File: rtl/pll_phase_divider.sv
// Multi-channel phase-programmable clock-enable generator with shadow config, common sync and lock.
// Latency: config takes effect at the next sync; outputs are register decodes except the bypass gate.
// cfgready drops while any channel is in its start delay; a held cfgvalid waits for it.
module pll_phase_divider
  import pll_phase_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int PH_W        = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic              referenceclk,
  input  logic              resetb,
  input  logic              bypass,
  input  logic              sync,
  input  logic              cfgvalid,
  output logic              cfgready,
  input  logic [CH_W-1:0]   cfgch,
  input  logic [DIV_W-1:0]  cfgdiv,
  input  logic [PH_W-1:0]   cfgphase,
  input  logic              cfgen,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] phaseout,
  output logic              lock
);

  localparam int LK_W = $clog2(LOCK_CYCLES + 1);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [PH_W-1:0]  phase;
    logic             en;
  } shadow_cfg_t;

  shadow_cfg_t       shadow [NUM_CH];
  logic [NUM_CH-1:0] ch_clken, ch_phase, ch_delay;
  logic [LK_W-1:0]   lock_cnt;
  logic              cfg_fire;

  assign cfgready = ~|ch_delay;
  assign cfg_fire = cfgvalid & cfgready;

  // Shadow config: written on handshake, out-of-range channels dropped; running channels unaffected.
  always_ff @(posedge referenceclk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_CH; i++)
        shadow[i] <= '{div: DIV_W'(DEFAULT_DIV), phase: '0, en: 1'b0};
    end else if (cfg_fire && (32'(cfgch) < NUM_CH)) begin
      shadow[cfgch] <= '{div: cfgdiv, phase: cfgphase, en: cfgen};
    end
  end

  // Lock counter: restarts on sync, counts cycles with no channel still delaying, saturates.
  always_ff @(posedge referenceclk or negedge resetb) begin
    if (!resetb)
      lock_cnt <= '0;
    else if (sync)
      lock_cnt <= '0;
    else if (!(|ch_delay) && (lock_cnt != LK_W'(LOCK_CYCLES)))
      lock_cnt <= lock_cnt + LK_W'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pll_phase_chan #(
      .DIV_W (DIV_W),
      .PH_W  (PH_W)
    ) u_chan (
      .referenceclk (referenceclk),
      .resetb       (resetb),
      .sync         (sync),
      .cfg_div      (shadow[g].div),
      .cfg_phase    (shadow[g].phase),
      .cfg_en       (shadow[g].en),
      .clken        (ch_clken[g]),
      .phaseout     (ch_phase[g]),
      .in_delay     (ch_delay[g])
    );
  end

  // Bypass is a pure output gate; counters and lock keep running underneath it.
  assign clken    = bypass ? {NUM_CH{1'b1}} : ch_clken;
  assign phaseout = bypass ? {NUM_CH{1'b0}} : ch_phase;
  assign lock     = (lock_cnt == LK_W'(LOCK_CYCLES));

endmodule

// File: tb/tb_pll_phase_divider.sv
// Scoreboard bench: the driver advances a cycle-level reference model and queues expectations.
// The monitor pops one expectation per cycle and compares; directed timing checks are evaluated at the end.
// Inputs change 1 time unit after the falling edge; outputs are sampled on the falling edge.
module tb_pll_phase_divider;

  localparam int NUM_CH      = 4;
  localparam int CH_W        = 2;
  localparam int LOCK_CYCLES = 16;
  localparam int DEFAULT_DIV = 4;
  localparam int HIST        = 4096;

  logic              referenceclk;
  logic              resetb, bypass, sync, cfgvalid, cfgready, cfgen, lock;
  logic [CH_W-1:0]   cfgch;
  logic [7:0]        cfgdiv, cfgphase;
  logic [NUM_CH-1:0] clken, phaseout;

  pll_phase_divider dut (
    .referenceclk (referenceclk),
    .resetb       (resetb),
    .bypass       (bypass),
    .sync         (sync),
    .cfgvalid     (cfgvalid),
    .cfgready     (cfgready),
    .cfgch        (cfgch),
    .cfgdiv       (cfgdiv),
    .cfgphase     (cfgphase),
    .cfgen        (cfgen),
    .clken        (clken),
    .phaseout     (phaseout),
    .lock         (lock)
  );

  initial referenceclk = 1'b0;
  always #5 referenceclk = ~referenceclk;

  typedef struct {
    int                c;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] po;
    logic              lk;
    logic              rdy;
  } exp_t;

  typedef struct {
    string name;
    int    kind;   // 0 first clken, 1 first lock, 2 first cfgready, 3 captured value
    int    ch;
    int    from;
    int    expv;
    int    actv;
  } dir_t;

  exp_t exp_q[$];
  dir_t dq[$];
  exp_t cur;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  bit done    = 1'b0;

  logic [NUM_CH-1:0] h_ce [HIST];
  bit                h_lock [HIST];
  bit                h_rdy [HIST];

  // Reference model: shadow config, config snapshot from the last sync, lock count.
  int sh_div [NUM_CH];
  int sh_ph  [NUM_CH];
  bit sh_en  [NUM_CH];
  int sn_div [NUM_CH];
  int sn_ph  [NUM_CH];
  bit sn_en  [NUM_CH];
  int sn_k;
  bit synced;
  int lcnt;
  bit m_hs;

  // Cycle c is ready unless some enabled channel is inside its delay window sn_k+1 .. sn_k+P.
  function automatic bit m_ready(int c);
    if (!synced) return 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (sn_en[i] && sn_ph[i] > 0 && c >= sn_k + 1 && c <= sn_k + sn_ph[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_chan(int i, int c, output bit ce, output bit po);
    int n, s, e;
    ce = 1'b0;
    po = 1'b0;
    if (!synced || !sn_en[i]) return;
    n = (sn_div[i] == 0) ? 1 : sn_div[i];
    s = sn_k + 1 + sn_ph[i];
    if (c < s) return;
    e  = (c - s) % n;
    ce = (e == 0);
    po = (e < (n + 1) / 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      sh_div[i] = DEFAULT_DIV;
      sh_ph[i]  = 0;
      sh_en[i]  = 1'b0;
    end
    synced = 1'b0;
    lcnt   = 0;
    m_hs   = 1'b0;
  endtask

  // Edge ecnt ends cycle ecnt; expectation is for cycle ecnt+1.
  task automatic model_edge();
    exp_t x;
    bit   rd, b1, b2;
    rd   = m_ready(ecnt);
    m_hs = cfgvalid && rd;
    if (sync) lcnt = 0;
    else if (rd && lcnt < LOCK_CYCLES) lcnt++;
    if (sync) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sn_div[i] = sh_div[i];
        sn_ph[i]  = sh_ph[i];
        sn_en[i]  = sh_en[i];
      end
      sn_k   = ecnt;
      synced = 1'b1;
    end
    if (m_hs && int'(cfgch) < NUM_CH) begin
      sh_div[cfgch] = int'(cfgdiv);
      sh_ph[cfgch]  = int'(cfgphase);
      sh_en[cfgch]  = cfgen;
    end
    x.c = ecnt + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      m_chan(i, ecnt + 1, b1, b2);
      x.ce[i] = b1;
      x.po[i] = b2;
    end
    if (bypass) begin
      x.ce = '1;
      x.po = '0;
    end
    x.lk  = (lcnt == LOCK_CYCLES);
    x.rdy = m_ready(ecnt + 1);
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge referenceclk);
    ecnt++;
    if (!resetb) model_reset();
    else model_edge();
    @(negedge referenceclk);
    #1;
  endtask

  task automatic add_dir(string name, int kind, int ch, int from, int expv, int actv);
    dir_t d;
    d.name = name; d.kind = kind; d.ch = ch; d.from = from; d.expv = expv; d.actv = actv;
    dq.push_back(d);
  endtask

  task automatic hold_until_hs();
    for (int i = 0; i < 1000 && !m_hs; i++) tick();
    if (!m_hs) add_dir("cfg_write_timeout", 3, 0, ecnt, 1, 0);
    cfgvalid = 1'b0;
  endtask

  task automatic cfg_write(int ch, int dv, int ph, bit en);
    cfgvalid = 1'b1;
    cfgch    = CH_W'(ch);
    cfgdiv   = 8'(dv);
    cfgphase = 8'(ph);
    cfgen    = en;
    tick();
    hold_until_hs();
  endtask

  task automatic sync_pulse(output int k);
    sync = 1'b1;
    tick();
    k    = ecnt;
    sync = 1'b0;
  endtask

  task automatic chk(string name, int c, int act, int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, expv);
    end
  endtask

  function automatic int first_hit(int kind, int ch, int from);
    for (int c = from; c < from + 1000 && c < HIST; c++) begin
      if (kind == 0 && h_ce[c][ch]) return c;
      if (kind == 1 && h_lock[c]) return c;
      if (kind == 2 && h_rdy[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: one expectation per cycle, then directed checks and the summary once the driver is done.
  initial begin
    forever begin
      @(negedge referenceclk);
      if (resetb && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("clken",    cur.c, int'(clken),    int'(cur.ce));
        chk("phaseout", cur.c, int'(phaseout), int'(cur.po));
        chk("lock",     cur.c, int'(lock),     int'(cur.lk));
        chk("cfgready", cur.c, int'(cfgready), int'(cur.rdy));
        if (cur.c < HIST) begin
          h_ce[cur.c]   = clken;
          h_lock[cur.c] = lock;
          h_rdy[cur.c]  = cfgready;
        end
      end else if (done && exp_q.size() == 0) begin
        foreach (dq[i])
          chk(dq[i].name, dq[i].from,
              (dq[i].kind == 3) ? dq[i].actv : first_hit(dq[i].kind, dq[i].ch, dq[i].from),
              dq[i].expv);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  // Driver.
  initial begin
    int k, k2, dv;
    resetb = 1'b0; bypass = 1'b0; sync = 1'b0; cfgvalid = 1'b0;
    cfgch = '0; cfgdiv = '0; cfgphase = '0; cfgen = 1'b0;
    repeat (3) tick();
    resetb = 1'b1;
    repeat (20) tick();

    // Two channels, N=4, phases 0 and 2.
    cfg_write(0, 4, 0, 1'b1);
    cfg_write(1, 4, 2, 1'b1);
    sync_pulse(k);
    add_dir("t2_ch0_first_clken", 0, 0, k + 1, k + 1, 0);
    add_dir("t2_ch1_first_clken", 0, 1, k + 1, k + 3, 0);
    add_dir("t2_first_lock",      1, 0, k + 1, k + 19, 0);
    repeat (30) tick();

    // Odd ratio, N=0, N=1 and a disabled channel.
    cfg_write(0, 3, 0, 1'b1);
    cfg_write(1, 0, 1, 1'b1);
    cfg_write(2, 1, 0, 1'b1);
    cfg_write(3, 7, 0, 1'b0);
    sync_pulse(k);
    repeat (25) tick();

    // Sync with a concurrent write: old ratio until the next sync.
    cfg_write(0, 4, 0, 1'b1);
    sync_pulse(k);
    repeat (10) tick();
    cfgvalid = 1'b1; cfgch = 2'd0; cfgdiv = 8'd6; cfgphase = 8'd0; cfgen = 1'b1;
    sync = 1'b1;
    tick();
    k = ecnt;
    sync = 1'b0;
    hold_until_hs();
    add_dir("t5_old_period", 0, 0, k + 2, k + 5, 0);
    repeat (20) tick();
    sync_pulse(k);
    add_dir("t5_new_period", 0, 0, k + 2, k + 7, 0);
    repeat (12) tick();
    bypass = 1'b1;
    repeat (8) tick();
    bypass = 1'b0;

    // Randomised config, syncs (some with concurrent writes) and bypass toggles.
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 3; w++) begin
        dv = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 9);
        cfg_write($urandom_range(0, NUM_CH - 1), dv, $urandom_range(0, 12), 1'($urandom_range(0, 3) != 0));
      end
      if ($urandom_range(0, 1) == 1) begin
        cfgvalid = 1'b1; cfgch = CH_W'($urandom_range(0, NUM_CH - 1));
        cfgdiv = 8'($urandom_range(0, 9)); cfgphase = 8'($urandom_range(0, 5)); cfgen = 1'b1;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        hold_until_hs();
      end else begin
        sync_pulse(k);
      end
      for (int i = 0; i < int'($urandom_range(20, 50)); i++) begin
        if ($urandom_range(0, 15) == 0) bypass = ~bypass;
        tick();
      end
      bypass = 1'b0;
    end

    // Long delay, sync re-issued mid-delay, config held across the delay.
    cfg_write(0, 5, 200, 1'b1);
    cfg_write(1, 4, 0, 1'b0);
    cfg_write(2, 4, 0, 1'b0);
    cfg_write(3, 4, 0, 1'b0);
    sync_pulse(k);
    repeat (49) tick();
    sync_pulse(k2);
    add_dir("t4_resync_spacing", 3, 0, k2, k + 50, k2);
    add_dir("t4_ready_after_delay", 2, 0, k2 + 1, k2 + 201, 0);
    add_dir("t4_ch0_first_clken",   0, 0, k2 + 1, k2 + 201, 0);
    add_dir("t4_first_lock",        1, 0, k2 + 1, k2 + 217, 0);
    cfg_write(2, 3, 0, 1'b1);
    repeat (40) tick();

    // Asynchronous reset while running, checked before any clock edge.
    #2;
    resetb = 1'b0;
    #1;
    add_dir("reset_outputs_no_edge", 3, 0, ecnt, 1, int'({clken, phaseout, lock, cfgready}));
    tick();
    tick();
    resetb = 1'b1;
    repeat (20) tick();
    done = 1'b1;
  end

endmodule
